// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (ps2_host_tx, ps2_line_sync,
// and the receiver that sits beside them).
//
// Contents:
//   - FSM state encoding for the host transmitter
//   - Common keyboard command bytes
//   - Frame parity helper
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Transmitter FSM states. Kept as plain 3-bit constants so older code
    // that compares against raw encodings keeps working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Keyboard command bytes and the acknowledge the keyboard sends back.
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the total count of ones
    // across data + parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// -----------------------------------------------------------------------------
// ps2_line_sync
// Brings the asynchronous PS/2 clock and data line levels into the clk domain
// and produces a single-cycle strobe on each falling edge of the PS/2 clock.
// Shared by the host transmitter and the receiver.
//
// Build option:
//   PS2_TX_GLITCH_FILTER_EN - when defined, the synchronized PS/2 clock goes
//   through an 8-sample stability filter before edge detection. The filtered
//   level only changes after 8 consecutive identical samples, adding 8 cycles
//   of latency to the fall strobe. When undefined, fall comes straight from
//   the 2-flop synchronized clock.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clk_in    in   raw PS/2 clock line level (asynchronous)
//   data_in   in   raw PS/2 data line level (asynchronous)
//   clk_sync  out  2-flop synchronized PS/2 clock level
//   data_sync out  2-flop synchronized PS/2 data level
//   fall      out  one-cycle strobe: PS/2 clock was 1 last cycle, 0 now
// -----------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    // Bit 0 = PS/2 clock, bit 1 = PS/2 data.
    logic [1:0] line_async;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic       clk_level;
    logic       clk_prev_reg;

    assign line_async = {data_in, clk_in};

    // Idle bus is high (pull-ups), so synchronizers reset to 1. That keeps
    // a fall strobe from firing on the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
        end else begin
            meta_reg <= line_async;
            sync_reg <= meta_reg;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic       filt_reg;
    logic [2:0] stable_cnt_reg;

    // Count consecutive samples that disagree with the current filtered
    // level; accept the new level on the 8th. Any agreeing sample restarts
    // the count, so a short glitch never reaches the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_reg       <= 1'b1;
            stable_cnt_reg <= 3'd0;
        end else if (sync_reg[0] == filt_reg) begin
            stable_cnt_reg <= 3'd0;
        end else if (stable_cnt_reg == 3'd7) begin
            filt_reg       <= sync_reg[0];
            stable_cnt_reg <= 3'd0;
        end else begin
            stable_cnt_reg <= stable_cnt_reg + 3'd1;
        end
    end

    assign clk_level = filt_reg;
`else
    assign clk_level = sync_reg[0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= clk_level;
        end
    end

    assign fall      = clk_prev_reg & ~clk_level;
    assign clk_sync  = sync_reg[0];
    assign data_sync = sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// (e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable) over the open-drain PS/2
// clock and data lines, following the device-generated clock, and reports
// whether the device acknowledged.
//
// Frame sequence:
//   1. Hold the clock low for INHIBIT_CYCLES (request-to-send).
//   2. Pull data low (start bit) and release the clock.
//   3. On each device clock fall, present the next bit: 8 data bits LSB
//      first, then odd parity, then release data for the stop bit.
//   4. On the 11th fall, sample data: low = ACK, high = NACK.
//   5. After an ACK, wait for both lines to return high, then pulse tx_done.
//   A timeout counter running from clock release aborts the frame with
//   tx_err if the device stalls.
//
// The receiver sharing these lines must ignore them while tx_busy is high.
//
// Build option:
//   PS2_TX_GLITCH_FILTER_EN - enables the PS/2 clock stability filter inside
//   ps2_line_sync (adds 8 cycles of edge latency).
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the clock is held low before the start bit
//   TIMEOUT_CYCLES  max clk cycles from clock release to end of the ACK bit
//   CNT_W           width of the shared inhibit/timeout counter
//                   (2**CNT_W must exceed TIMEOUT_CYCLES)
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   synchronous active-high reset
//   tx_start     in   one-cycle send request, honoured only when idle
//   tx_data[7:0] in   command byte, captured with tx_start
//   PS2clk_in    in   PS/2 clock line level (asynchronous)
//   key_data_in  in   PS/2 data line level (asynchronous)
//   PS2clk_oe    out  1 pulls the PS/2 clock low, 0 releases it
//   key_data_oe  out  1 pulls the PS/2 data low, 0 releases it
//   tx_busy      out  high from request acceptance until back in idle
//   tx_done      out  one-cycle pulse on a successful ACK
//   tx_err       out  one-cycle pulse on timeout or NACK
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       PS2clk_in,
    input  logic       key_data_in,
    output logic       PS2clk_oe,
    output logic       key_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    // Terminal counts for the shared counter. Both phases count from 0, so
    // reaching N-1 means N cycles have elapsed.
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic       ps2_clk_sync;
    logic       ps2_data_sync;
    logic       ps2_fall;

    logic [2:0]       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [8:0]       shift_reg,   shift_next;
    logic             clk_oe_reg,  clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             busy_reg,    busy_next;
    logic             done_reg,    done_next;
    logic             err_reg,     err_next;
    logic             timeout_hit;

    ps2_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (PS2clk_in),
        .data_in   (key_data_in),
        .clk_sync  (ps2_clk_sync),
        .data_sync (ps2_data_sync),
        .fall      (ps2_fall)
    );

    assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        clk_oe_next  = clk_oe_reg;
        data_oe_next = data_oe_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Line activity here belongs to the receiver; only a
                // request moves us on.
                if (tx_start) begin
                    shift_next   = {odd_parity(tx_data), tx_data};
                    bit_cnt_next = 4'd0;
                    cnt_next     = '0;
                    clk_oe_next  = 1'b1;
                    data_oe_next = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    // Start bit goes out with the clock release; from here
                    // the device owns the clock and the timeout starts.
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_SEND;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_SEND, ST_STOP, ST_ACK, ST_WAIT_IDLE: begin
                // Timeout is checked first so it wins over a fall that
                // lands in the same cycle.
                if (timeout_hit) begin
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    busy_next    = 1'b0;
                    err_next     = 1'b1;
                    cnt_next     = '0;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    case (state_reg)
                        ST_SEND: begin
                            if (ps2_fall) begin
                                // Open drain: drive low for a 0 bit.
                                data_oe_next = ~shift_reg[0];
                                shift_next   = {1'b0, shift_reg[8:1]};
                                if (bit_cnt_reg == 4'd8) begin
                                    state_next = ST_STOP;
                                end else begin
                                    bit_cnt_next = bit_cnt_reg + 4'd1;
                                end
                            end
                        end
                        ST_STOP: begin
                            if (ps2_fall) begin
                                data_oe_next = 1'b0;
                                state_next   = ST_ACK;
                            end
                        end
                        ST_ACK: begin
                            if (ps2_fall) begin
                                if (!ps2_data_sync) begin
                                    state_next = ST_WAIT_IDLE;
                                end else begin
                                    clk_oe_next  = 1'b0;
                                    data_oe_next = 1'b0;
                                    busy_next    = 1'b0;
                                    err_next     = 1'b1;
                                    cnt_next     = '0;
                                    state_next   = ST_IDLE;
                                end
                            end
                        end
                        default: begin
                            // ST_WAIT_IDLE: device must let both lines float
                            // high before the bus is considered free again.
                            if (ps2_clk_sync && ps2_data_sync) begin
                                busy_next  = 1'b0;
                                done_next  = 1'b1;
                                cnt_next   = '0;
                                state_next = ST_IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                busy_next    = 1'b0;
                cnt_next     = '0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 9'd0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            clk_oe_reg  <= clk_oe_next;
            data_oe_reg <= data_oe_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign PS2clk_oe   = clk_oe_reg;
    assign key_data_oe = data_oe_reg;
    assign tx_busy     = busy_reg;
    assign tx_done     = done_reg;
    assign tx_err      = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx. A behavioural PS/2 keyboard drives the
// open-drain lines, samples the bits the host sends on its rising clock
// edges and optionally acknowledges. Expected bits come from the command
// byte (LSB first), odd parity counted with $countones, and a released stop
// bit. Short inhibit/timeout parameters keep the run small.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 3000;
    localparam int CW  = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       PS2clk_in;
    logic       key_data_in;
    logic       PS2clk_oe;
    logic       key_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    // Device side of the open-drain bus: 1 = released.
    logic dev_clk;
    logic dev_data;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int busy_bad = 0;

    always #5 clk = ~clk;

    assign PS2clk_in   = dev_clk  & ~PS2clk_oe;
    assign key_data_in = dev_data & ~key_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .PS2clk_in   (PS2clk_in),
        .key_data_in (key_data_in),
        .PS2clk_oe   (PS2clk_oe),
        .key_data_oe (key_data_oe),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // Pulse monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_done) done_cnt++;
            if (tx_err)  err_cnt++;
            if (tx_done && tx_err) both_cnt++;
            if ((tx_done || tx_err) && tx_busy) busy_bad++;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        int         half;
        int         req_at;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start_latency_clk_oe", int'(PS2clk_oe), 1);
        check("start_busy", int'(tx_busy), 1);
    endtask

    // Called right after start_tx; counts cycles the host holds the clock.
    task automatic wait_release(output int inh_len);
        inh_len = 1;
        for (int k = 0; k < INH * 4; k++) begin
            @(negedge clk);
            if (!PS2clk_oe) break;
            inh_len++;
        end
    endtask

    // One device clock period; the bit is read on the rising edge.
    task automatic dev_bit(input int half, output logic sampled);
        repeat (half) @(negedge clk);
        dev_clk = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b1;
        sampled = key_data_in;
    endtask

    task automatic run_full(input logic [7:0] d, input bit ack, input bit exp_par,
                            input int half, input int req_at);
        int         inh;
        int         d0;
        int         e0;
        logic       b;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        wait_release(inh);
        check("inhibit_len", inh, INH);
        check("start_bit_oe", int'(key_data_oe), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == req_at) begin
                @(negedge clk);
                tx_data  = PS2_CMD_ENABLE;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                check("busy_during_ignored_req", int'(tx_busy), 1);
            end
            dev_bit(half, b);
            bits[i] = b;
        end
        for (int j = 0; j < 8; j++) begin
            check($sformatf("data_bit%0d", j), int'(bits[j]), int'(d[j]));
        end
        check("parity_bit", int'(bits[8]), int'(exp_par));
        check("stop_bit", int'(bits[9]), 1);
        // 11th clock: the ACK bit.
        repeat (half / 2) @(negedge clk);
        if (ack) dev_data = 1'b0;
        repeat (half - half / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (half) @(negedge clk);
        dev_clk = 1'b1;
        repeat (half) @(negedge clk);
        dev_data = 1'b1;
        for (int k = 0; k < TO + 100; k++) begin
            if ((done_cnt - d0) + (err_cnt - e0) > 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - d0, ack ? 1 : 0);
        check("err_pulses", err_cnt - e0, ack ? 0 : 1);
        check("end_busy", int'(tx_busy), 0);
        check("end_clk_oe", int'(PS2clk_oe), 0);
        check("end_data_oe", int'(key_data_oe), 0);
        $display("frame data=%02h ack=%0d half=%0d inhibit=%0d bits=%010b done=%0d err=%0d",
                 d, ack, half, inh, bits, done_cnt - d0, err_cnt - e0);
    endtask

    initial begin
        int         inh;
        int         c;
        int         e0;
        logic       b;
        logic [7:0] r;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_clk_oe", int'(PS2clk_oe), 0);
        check("reset_data_oe", int'(key_data_oe), 0);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_done", int'(tx_done), 0);
        check("reset_err", int'(tx_err), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed table entries, then randomized ones checked with the model.
        vecs[0] = '{PS2_CMD_SET_LED, 1'b1, 1'b1, 20, -1};
        vecs[1] = '{8'h00,           1'b1, 1'b1, 18, -1};
        vecs[2] = '{8'hFF,           1'b1, 1'b1, 22, -1};
        vecs[3] = '{8'h01,           1'b1, 1'b0, 16, -1};
        vecs[4] = '{PS2_CMD_ENABLE,  1'b0, 1'b0, 20, -1};
        vecs[5] = '{PS2_CMD_RESET,   1'b1, 1'b1, 20,  3};
        vecs[6] = '{PS2_ACK_BYTE,    1'b1, 1'b1, 24, -1};
        for (int i = 7; i < 12; i++) begin
            r = 8'($urandom);
            vecs[i].data    = r;
            vecs[i].ack     = ($urandom_range(0, 3) != 0);
            vecs[i].exp_par = ($countones(r) % 2 == 0);
            vecs[i].half    = int'($urandom_range(16, 30));
            vecs[i].req_at  = -1;
        end
        for (int i = 0; i < 12; i++) begin
            run_full(vecs[i].data, vecs[i].ack, vecs[i].exp_par, vecs[i].half, vecs[i].req_at);
        end

        // Line activity while idle must not start anything.
        e0 = done_cnt + err_cnt;
        for (int k = 0; k < 6; k++) begin
            repeat (12) @(negedge clk);
            dev_clk  = ~dev_clk;
            dev_data = (k % 3 != 0);
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (15) @(negedge clk);
        check("idle_noise_busy", int'(tx_busy), 0);
        check("idle_noise_clk_oe", int'(PS2clk_oe), 0);
        check("idle_noise_pulses", done_cnt + err_cnt - e0, 0);
        $display("idle line activity: busy=%0d pulses=%0d", tx_busy, done_cnt + err_cnt - e0);

        // Timeout: device never clocks after release.
        start_tx(PS2_CMD_RESET);
        wait_release(inh);
        check("timeout_inhibit_len", inh, INH);
        c = 0;
        for (int k = 0; k < TO + 50; k++) begin
            @(negedge clk);
            c++;
            if (tx_err) break;
        end
        check("timeout_cycles", c, TO);
        check("timeout_busy", int'(tx_busy), 0);
        check("timeout_clk_oe", int'(PS2clk_oe), 0);
        check("timeout_data_oe", int'(key_data_oe), 0);
        $display("timeout: err after %0d cycles from clock release", c);
        repeat (5) @(negedge clk);

        // Reset after fall 4, then a clean frame.
        start_tx(8'h00);
        wait_release(inh);
        for (int i = 0; i < 4; i++) dev_bit(20, b);
        check("pre_reset_data_oe", int'(key_data_oe), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_clk_oe", int'(PS2clk_oe), 0);
        check("midreset_data_oe", int'(key_data_oe), 0);
        check("midreset_busy", int'(tx_busy), 0);
        $display("mid-frame reset: clk_oe=%0d data_oe=%0d busy=%0d", PS2clk_oe, key_data_oe, tx_busy);
        repeat (5) @(negedge clk);
        run_full(PS2_CMD_ENABLE, 1'b1, 1'b0, 20, -1);

        check("done_err_overlap", both_cnt, 0);
        check("busy_at_pulse", busy_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
